alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
Registered writeback stage directly downstream of the 8-bit ALU. It captures the ALU result and flags through a valid/ready handshake, buffers them in a 2-entry skid buffer, and builds the architectural NZVC flags. It sequences multi-byte (chained) arithmetic by feeding the registered carry/borrow back to the ALU Cin input, and accumulates Zero across the bytes of a chain.

Parameters:
CHAIN_MAX, 4, maximum bytes in one chained operation (range 2..16); counter width is clog2(CHAIN_MAX).

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept; registered
alu_cont  input  4  ALU control code used for this result
alu_x  input  8  ALU result X
alu_zero  input  1  ALU Zero for this byte
alu_ovf  input  1  ALU Overflow
alu_cout  input  1  ALU Cout
chain  input  1  another byte of the same operation follows
cin_out  output  1  carry to drive ALU Cin; registered
out_valid  output  1  output entry valid
out_ready  input  1  consumer accepts
out_x  output  8  result byte
out_flags  output  4  {N,Z,V,C}
out_last  output  1  final byte of the operation
chain_err  output  1  one-cycle pulse when chain is truncated at CHAIN_MAX
ovf_count  output  16  saturating overflow count (optional feature)

Behaviour:
- Reset (async, rst_n=0): in_ready=1, out_valid=0, out_x=0, out_flags=0, out_last=0, cin_out=0, chain_err=0, ovf_count=0, state IDLE, byte counter 0, z_acc=1. Reset mid-chain discards the chain and both buffer entries.
- Accept: in_valid & in_ready. Accept-to-out_valid latency is 1 cycle when the output register is empty or drains in the same cycle.
- Arith ops: alu_cont in {0010,0110,1010,1110}. SLT ops: alu_cont[1:0]=11. All other codes are logic ops.
- Flags per byte:
  - N = alu_x[7].
  - Z = alu_zero & z_acc, where z_acc=1 in IDLE.
  - V = alu_ovf for arith ops, else 0.
  - C = alu_cout for arith ops, else 0.
  - SLT ops: N=0, V=0, C=0, Z=(alu_x==0).
- FSM:
  - IDLE: cin_out=0. On accept with chain=1 and an arith op, go to CHAIN; count=1, carry_q=alu_cout, z_acc=alu_zero.
  - CHAIN: cin_out=carry_q. On accept with chain=1 and count<CHAIN_MAX-1, stay; count++, carry_q=alu_cout, z_acc&=alu_zero.
  - CHAIN: on accept with chain=0, or when count reaches CHAIN_MAX-1, return to IDLE, clear count, set z_acc=1, carry_q=0.
  - Forced termination: chain_err pulses for 1 cycle, and that byte gets out_last=1.
- chain=1 on a logic or SLT op is ignored: treated as chain=0, out_last=1, and the FSM goes to IDLE. This applies in either state; a logic/SLT byte inside a chain terminates the chain.
- out_last = ~(effective chain) at accept.
- Skid buffer:
  - Entries are main (drives outputs) and skid.
  - Accept while main is valid and not draining: write to skid; in_ready=0 from the next cycle.
  - Main drains (out_valid & out_ready) while skid is valid: skid moves to main; in_ready=1 next cycle.
  - Simultaneous accept and drain with skid empty: new data goes to main, no bubble.
  - Order is always preserved.
  - Payload is stable while out_valid=1 and out_ready=0.
- cin_out updates on the accepting edge and is valid for the next ALU byte presented.

Optional Feature:
ALU_RESULT_STATS_EN:
- When defined: ovf_count increments on each accepted arith byte with alu_ovf=1, saturates at 0xFFFF, and resets to 0.
- When not defined: ovf_count is tied to 0 and the counter logic is absent.
- The port exists in both cases.

Test Plan:
- 16-bit add 0x01FF+0x0001. Byte0 alu_x=0x00, cout=1, chain=1 → out Z=1, C=1, last=0; cin_out=1. Byte1 alu_x=0x02, zero=0, chain=0 → Z=0, last=1; cin_out=0.
- 16-bit subtract 0x1234-0x1234. Both bytes alu_zero=1 → byte1 flags Z=1, last=1. Repeat with byte0 zero=0 and byte1 zero=1 → byte1 Z=0.
- Backpressure. out_ready=0, accept 3 back-to-back → first two accepted, in_ready=0 after the second, third stalls. Raise out_ready → bytes appear in order with no loss or duplication, and in_ready returns.
- Truncation with CHAIN_MAX=4. Five chain=1 arith bytes → 4th byte last=1 with a chain_err pulse; 5th byte starts a new chain, cin_out before it =0.
- SLT op 0111 with chain=1 and alu_x=0x01 → out_x=0x01, flags 0000, last=1, FSM in IDLE.
- Reset mid-chain after byte0 → out_valid=0, cin_out=0, in_ready=1 immediately. Stats build: 3 overflowing arith bytes → ovf_count=3.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU writeback stage: NZVC flag build, chained-carry sequencing and a 2-entry skid buffer.
// Optional saturating overflow counter enabled by defining ALU_RESULT_STATS_EN.
module alu_result_stage #(
  parameter int unsigned CHAIN_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_cont,
  input  logic [7:0]  alu_x,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_cout,
  input  logic        chain,
  output logic        cin_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_x,
  output logic [3:0]  out_flags,
  output logic        out_last,
  output logic        chain_err,
  output logic [15:0] ovf_count
);

  localparam int unsigned CW = (CHAIN_MAX > 1) ? $clog2(CHAIN_MAX) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_MAX - 1);

  typedef enum logic {IDLE, CHAIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          z_acc, z_acc_nx, carry_nx, err_nx;

  logic accept, is_arith, is_slt, want_chain, at_limit, forced, eff_chain;
  logic flag_n, flag_z, flag_v, flag_c;
  logic [12:0] in_pl, main_pl, skid_pl;
  logic main_valid, skid_valid, drain;

  assign accept     = in_valid & in_ready;
  assign is_arith   = alu_cont inside {4'b0010, 4'b0110, 4'b1010, 4'b1110};
  assign is_slt     = (alu_cont[1:0] == 2'b11);
  assign want_chain = chain & is_arith;
  assign at_limit   = (state == CHAIN) && (count == LAST_CNT);
  assign forced     = want_chain & at_limit;
  assign eff_chain  = want_chain & ~at_limit;

  // z_acc is held at 1 in IDLE, so the AND covers the first byte too
  assign flag_n = is_slt ? 1'b0 : alu_x[7];
  assign flag_z = is_slt ? (alu_x == 8'h00) : (alu_zero & z_acc);
  assign flag_v = is_arith & alu_ovf;
  assign flag_c = is_arith & alu_cout;
  assign in_pl  = {alu_x, flag_n, flag_z, flag_v, flag_c, ~eff_chain};

  always_comb begin
    state_nx = state;
    count_nx = count;
    z_acc_nx = z_acc;
    carry_nx = cin_out;
    err_nx   = 1'b0;
    if (accept) begin
      if (eff_chain) begin
        state_nx = CHAIN;
        count_nx = count + CW'(1);
        z_acc_nx = z_acc & alu_zero;
        carry_nx = alu_cout;
      end else begin
        state_nx = IDLE;
        count_nx = '0;
        z_acc_nx = 1'b1;
        carry_nx = 1'b0;
        err_nx   = forced;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      z_acc     <= 1'b1;
      cin_out   <= 1'b0;
      chain_err <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      z_acc     <= z_acc_nx;
      cin_out   <= carry_nx;
      chain_err <= err_nx;
    end
  end

  assign drain = main_valid & out_ready;

  // in_ready is simply "skid slot free next cycle", registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_pl    <= '0;
      skid_pl    <= '0;
      in_ready   <= 1'b1;
    end else begin
      if (accept) begin
        if (!main_valid || drain) begin
          main_valid <= 1'b1;
          main_pl    <= in_pl;
          in_ready   <= 1'b1;
        end else begin
          skid_valid <= 1'b1;
          skid_pl    <= in_pl;
          in_ready   <= 1'b0;
        end
      end else if (drain) begin
        if (skid_valid) begin
          main_pl    <= skid_pl;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= 1'b0;
        end
        in_ready <= 1'b1;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_x     = main_pl[12:5];
  assign out_flags = main_pl[4:1];
  assign out_last  = main_pl[0];

`ifdef ALU_RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_count <= '0;
    else if (accept && is_arith && alu_ovf && (ovf_count != 16'hFFFF))
      ovf_count <= ovf_count + 16'd1;
  end
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver pushes expected {x,flags,last}, monitor pops on each transfer.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, alu_zero, alu_ovf, alu_cout, chain;
  logic        cin_out, out_valid, out_ready, out_last, chain_err;
  logic [3:0]  alu_cont, out_flags;
  logic [7:0]  alu_x, out_x;
  logic [15:0] ovf_count;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  alu_result_stage #(.CHAIN_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cont(alu_cont), .alu_x(alu_x), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_cout(alu_cout), .chain(chain), .cin_out(cin_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_flags(out_flags), .out_last(out_last),
    .chain_err(chain_err), .ovf_count(ovf_count)
  );

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got x=%h flags=%b last=%b, required none",
                 out_x, out_flags, out_last);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({out_x, out_flags, out_last} !== e) begin
          fails++;
          $display("FAIL output: got x=%h flags=%b last=%b, required x=%h flags=%b last=%b",
                   out_x, out_flags, out_last, e[12:5], e[4:1], e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [3:0] cont, input logic [7:0] x, input logic zero,
                      input logic ovf, input logic cout, input logic ch,
                      input logic [3:0] ef, input logic el);
    int unsigned n = 0;
    logic done = 1'b0;
    alu_cont = cont; alu_x = x; alu_zero = zero; alu_ovf = ovf;
    alu_cout = cout; chain = ch; in_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (done) exp_q.push_back({x, ef, el});
    else begin
      tests++; fails++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance of x=%h", x);
    end
  endtask

  task automatic stop_in();
    in_valid = 1'b0;
    chain = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; alu_cont = '0; alu_x = '0;
    alu_zero = 1'b0; alu_ovf = 1'b0; alu_cout = 1'b0; chain = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'h1);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_payload", {3'b0, out_x, out_flags, out_last}, 16'h0);
    check("rst_cin_out", 16'(cin_out), 16'h0);
    check("rst_chain_err", 16'(chain_err), 16'h0);
    check("rst_ovf_count", ovf_count, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 16-bit add 0x01FF + 0x0001
    send(4'b0010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    check("add_b0_cin", 16'(cin_out), 16'h1);
    send(4'b0010, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    check("add_b1_cin", 16'(cin_out), 16'h0);
    stop_in();
    // 16-bit subtract, both bytes zero, then low byte nonzero
    send(4'b0110, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    send(4'b0110, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b1);
    send(4'b0110, 8'h10, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    send(4'b0110, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b1);
    // V on arith, V/C masked on logic
    send(4'b1110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1);
    send(4'b0100, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    stop_in();
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    send(4'b0000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1);
    send(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
    check("bp_in_ready_low", 16'(in_ready), 16'h0);
    alu_cont = 4'b0000; alu_x = 8'h3C; alu_zero = 1'b0; chain = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_stall_ready", 16'(in_ready), 16'h0);
    check("bp_stable_x", 16'(out_x), 16'h0080);
    out_ready = 1'b1;
    send(4'b0000, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    stop_in();
    wait_drain();
    check("bp_in_ready_back", 16'(in_ready), 16'h1);

    // Truncation at CHAIN_MAX=4
    send(4'b0010, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    send(4'b0010, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    send(4'b0010, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    check("trunc_b3_err", 16'(chain_err), 16'h0);
    check("trunc_b3_cin", 16'(cin_out), 16'h1);
    send(4'b0010, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1);
    check("trunc_b4_err", 16'(chain_err), 16'h1);
    check("trunc_b4_cin", 16'(cin_out), 16'h0);
    send(4'b0010, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0);
    check("trunc_b5_err", 16'(chain_err), 16'h0);
    check("trunc_b5_cin", 16'(cin_out), 16'h1);
    send(4'b0010, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

    // SLT with chain=1 is terminal; SLT zero result; logic op inside a chain ends it
    send(4'b0111, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1);
    check("slt_cin", 16'(cin_out), 16'h0);
    send(4'b1111, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
    send(4'b1010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    send(4'b0001, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1);
    check("logic_in_chain_cin", 16'(cin_out), 16'h0);
    stop_in();
    wait_drain();

    // Reset mid-chain
    out_ready = 1'b0;
    send(4'b0010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0);
    stop_in();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 16'(out_valid), 16'h0);
    check("midrst_cin", 16'(cin_out), 16'h0);
    check("midrst_in_ready", 16'(in_ready), 16'h1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'b0010, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1);
    check("postrst_cin", 16'(cin_out), 16'h0);

    // Overflow counting
    send(4'b0110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1);
    send(4'b0110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1);
    send(4'b0000, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    send(4'b0110, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b1);
    stop_in();
    wait_drain();
`ifdef ALU_RESULT_STATS_EN
    check("ovf_count", ovf_count, 16'd3);
`else
    check("ovf_count", ovf_count, 16'd0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
